// File: rtl/uart_rx_parity_ctrl.sv
// Avalon-MM UART receiver: 16x oversampling, optional even/odd parity,
// receive FIFO and sticky error flags behind four 32-bit registers.
module uart_rx_parity_ctrl #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd27
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        rxd,
  output logic        rx_parity,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t      r_state;
  logic        r_sync1, r_sync2;
  logic [15:0] r_div_cnt;
  logic [3:0]  r_smp;
  logic [2:0]  r_bit;
  logic [7:0]  r_data;
  logic        r_pe;
  logic [3:0]  r_ctrl;
  logic [15:0] r_div;
  logic [9:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic        r_ovr, r_pef, r_fef;

  logic        w_en, w_par_on, w_tick, w_samp;
  logic [1:0]  w_pmode;
  logic [15:0] w_div_eff;
  logic        w_rd, w_wr, w_div_wr, w_pop, w_push;
  logic        w_full, w_empty, w_accept, w_ovr_set;
  logic [9:0]  w_word;
  logic [2:0]  w_clr;
  logic        w_unused;

  assign w_en      = r_ctrl[0];
  assign w_pmode   = r_ctrl[2:1];
  assign w_par_on  = (w_pmode == 2'b01) | (w_pmode == 2'b10);
  assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;
  // >= so a smaller divisor written mid-count still terminates
  assign w_tick    = r_div_cnt >= (w_div_eff - 16'd1);
  assign w_samp    = w_tick & (r_smp == 4'd7);

  assign w_rd      = chipselect & read;
  assign w_wr      = chipselect & write;
  assign w_div_wr  = w_wr & (address == 2'd3);
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_pop     = w_rd & (address == 2'd0) & ~w_empty;
  assign w_push    = w_en & (r_state == S_STOP) & w_samp;
  assign w_word    = {~r_sync2, r_pe, r_data};
  assign w_accept  = w_push & (~w_full | w_pop);
  assign w_ovr_set = w_push & w_full & ~w_pop;
  assign w_clr     = (w_wr && address == 2'd1) ? writedata[4:2] : 3'd0;
  assign w_unused  = ^{writedata[31:16]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_div_cnt <= '0;
    else if (r_state == S_IDLE || w_div_wr || w_tick)
      r_div_cnt <= '0;
    else
      r_div_cnt <= r_div_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_smp   <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_pe    <= 1'b0;
    end else if (!w_en) begin
      r_state <= S_IDLE;
    end else if (r_state == S_IDLE) begin
      r_smp <= '0;
      r_bit <= '0;
      if (!r_sync2) begin
        r_state <= S_START;
        r_pe    <= 1'b0;
      end
    end else begin
      if (w_tick)
        r_smp <= r_smp + 4'd1;
      if (w_samp) begin
        case (r_state)
          S_START:
            r_state <= r_sync2 ? S_IDLE : S_DATA;
          S_DATA: begin
            r_data <= {r_sync2, r_data[7:1]};
            r_bit  <= r_bit + 3'd1;
            if (r_bit == 3'd7)
              r_state <= w_par_on ? S_PARITY : S_STOP;
          end
          S_PARITY: begin
            r_pe    <= (^{r_data, r_sync2}) ^ w_pmode[1];
            r_state <= S_STOP;
          end
          default:
            r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wp] <= w_word;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      if (w_accept && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (!w_accept && w_pop)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl    <= '0;
      r_div     <= DIV_RESET;
      r_ovr     <= 1'b0;
      r_pef     <= 1'b0;
      r_fef     <= 1'b0;
      rx_parity <= 1'b0;
      readdata  <= '0;
      irq       <= 1'b0;
    end else begin
      if (w_wr && address == 2'd2)
        r_ctrl <= writedata[3:0];
      if (w_div_wr)
        r_div <= writedata[15:0];
      r_ovr <= (r_ovr & ~w_clr[0]) | w_ovr_set;
      r_pef <= (r_pef & ~w_clr[1]) | (w_push & r_pe);
      r_fef <= (r_fef & ~w_clr[2]) | (w_push & ~r_sync2);
      if (w_push)
        rx_parity <= r_pe;
      if (w_rd) begin
        unique case (address)
          2'd0: readdata <= w_empty ? 32'd0
                          : {1'b1, 21'd0, r_mem[r_rp]};
          2'd1: readdata <= {27'd0, r_fef, r_pef, r_ovr,
                             w_full, ~w_empty};
          2'd2: readdata <= {28'd0, r_ctrl};
          2'd3: readdata <= {16'd0, r_div};
        endcase
      end
      irq <= r_ctrl[3] & (~w_empty | r_ovr | r_pef | r_fef);
    end
  end
endmodule

// File: tb/tb_uart_rx_parity_ctrl.sv
// Bench for uart_rx_parity_ctrl: directed frames plus random frames
// checked against a queue-based receiver model.
module tb_uart_rx_parity_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect, read, write, rxd;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  logic        rx_parity, irq;

  always #5 clk = ~clk;

  uart_rx_parity_ctrl dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect),
    .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .rxd(rxd),
    .rx_parity(rx_parity), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  logic [9:0] q[$];
  bit         m_ovr, m_pef, m_fef, m_rxp;
  logic [3:0] m_ctrl;
  int         m_div;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {27'd0, m_fef, m_pef, m_ovr, q.size() == 8, q.size() != 0};
  endfunction

  function automatic logic m_irq();
    return m_ctrl[3] & (q.size() != 0 | m_ovr | m_pef | m_fef);
  endfunction

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1; write = 1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 0; write = 0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1; read = 1; address = a;
    @(posedge clk); #1;
    chipselect = 0; read = 0;
    d = readdata;
  endtask

  task automatic wr_ctrl(input logic [3:0] v);
    bus_wr(2'd2, {28'd0, v});
    m_ctrl = v;
  endtask

  task automatic wr_div(input int v);
    bus_wr(2'd3, v);
    m_div = v;
  endtask

  task automatic clr_flags(input logic [31:0] mask);
    bus_wr(2'd1, mask);
    if (mask[2]) m_ovr = 0;
    if (mask[3]) m_pef = 0;
    if (mask[4]) m_fef = 0;
  endtask

  task automatic put_bit(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] data, input logic pbit,
                      input bit stopb);
    int bc;
    int mode;
    bit pe;
    bc = ((m_div == 0) ? 1 : m_div) * 16;
    mode = m_ctrl[2:1];
    @(posedge clk); #1;
    put_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) put_bit(data[i], bc);
    if (mode == 1 || mode == 2) put_bit(pbit, bc);
    if (stopb) put_bit(1'b1, bc);
    else begin
      put_bit(1'b0, bc * 3 / 4);
      put_bit(1'b1, bc / 4);
    end
    put_bit(1'b1, bc);
    if (mode == 1) pe = ($countones({data, pbit}) % 2) == 1;
    else if (mode == 2) pe = ($countones({data, pbit}) % 2) == 0;
    else pe = 0;
    if (q.size() < 8) q.push_back({!stopb, pe, data});
    else m_ovr = 1;
    m_pef |= pe;
    m_fef |= !stopb;
    m_rxp = pe;
  endtask

  task automatic rd_check(input string tag);
    logic [31:0] d, e;
    bus_rd(2'd0, d);
    e = (q.size() != 0) ? {1'b1, 21'd0, q.pop_front()} : 32'd0;
    check(tag, d, e);
  endtask

  task automatic rd_exp(input string tag, input logic [31:0] e);
    logic [31:0] d;
    bus_rd(2'd0, d);
    if (q.size() != 0) void'(q.pop_front());
    check(tag, d, e);
  endtask

  task automatic st_check(input string tag);
    logic [31:0] d;
    bus_rd(2'd1, d);
    check(tag, d, m_status());
  endtask

  task automatic model_reset();
    q.delete();
    m_ovr = 0; m_pef = 0; m_fef = 0; m_rxp = 0;
    m_ctrl = 4'd0; m_div = 27;
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  c;
    reset_n = 0; rxd = 1; chipselect = 0; read = 0; write = 0;
    address = 0; writedata = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_readdata", readdata, 32'd0);
    check("rst_rx_parity", {31'd0, rx_parity}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1;
    bus_rd(2'd3, d); check("rst_divisor", d, 32'd27);
    bus_rd(2'd2, d); check("rst_control", d, 32'd0);
    st_check("rst_status");

    wr_div(1);
    wr_ctrl(4'b0001);
    send(8'hA5, 1'b0, 1);
    check("a5_rxp", {31'd0, rx_parity}, 32'd0);
    rd_exp("a5_data", 32'h800000A5);
    bus_rd(2'd1, d); check("a5_status", d, 32'h0);

    wr_ctrl(4'b0011);
    send(8'h03, 1'b1, 1);
    check("even_rxp", {31'd0, rx_parity}, 32'd1);
    rd_exp("even_data", 32'h80000103);
    bus_rd(2'd1, d); check("even_st3", {31'd0, d[3]}, 32'd1);
    clr_flags(32'h08);
    bus_rd(2'd1, d); check("even_clr", {31'd0, d[3]}, 32'd0);

    wr_ctrl(4'b0101);
    send(8'h03, 1'b1, 0);
    check("odd_rxp", {31'd0, rx_parity}, 32'd0);
    rd_exp("odd_data", 32'h80000203);
    bus_rd(2'd1, d); check("odd_st4", {31'd0, d[4]}, 32'd1);
    clr_flags(32'h10);

    wr_ctrl(4'b0001);
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i), 1'b0, 1);
    bus_rd(2'd1, d); check("ovf_status", d, 32'h07);
    for (int i = 0; i < 8; i++)
      rd_exp($sformatf("ovf_rd%0d", i), 32'h80000010 + i);
    rd_exp("ovf_empty", 32'h0);
    clr_flags(32'h04);
    st_check("ovf_clr");

    @(posedge clk); #1;
    put_bit(1'b0, 4);
    put_bit(1'b1, 40);
    st_check("glitch_status");
    send(8'h5A, 1'b0, 1);
    rd_exp("glitch_next", 32'h8000005A);

    wr_ctrl(4'b1011);
    send(8'h03, 1'b1, 1);
    check("pre_rst_rxp", {31'd0, rx_parity}, 32'd1);
    check("pre_rst_irq", {31'd0, irq}, {31'd0, m_irq()});
    bus_rd(2'd3, d); check("pre_rst_div", d, 32'd1);
    @(posedge clk); #1;
    put_bit(1'b0, 16 + 40);
    reset_n = 0;
    #2;
    check("mid_rst_readdata", readdata, 32'd0);
    check("mid_rst_rxp", {31'd0, rx_parity}, 32'd0);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    rxd = 1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1;
    model_reset();
    st_check("post_rst_status");
    wr_div(1);
    wr_ctrl(4'b0001);
    send(8'hC3, 1'b0, 1);
    rd_exp("post_rst_data", 32'h800000C3);

    wr_ctrl(4'b1001);
    check("irq_idle", {31'd0, irq}, 32'd0);
    send(8'h77, 1'b0, 1);
    check("irq_set", {31'd0, irq}, 32'd1);
    rd_check("irq_pop");
    check("irq_lag", {31'd0, irq}, 32'd1);
    @(posedge clk); #1;
    check("irq_clr", {31'd0, irq}, 32'd0);

    for (int n = 0; n < 24; n++) begin
      c = 4'($urandom_range(0, 15)) | 4'd1;
      wr_div($urandom_range(0, 3));
      wr_ctrl(c);
      send(8'($urandom), 1'($urandom), $urandom_range(0, 4) != 0);
      check($sformatf("rnd%0d_rxp", n), {31'd0, rx_parity}, {31'd0, m_rxp});
      check($sformatf("rnd%0d_irq", n), {31'd0, irq}, {31'd0, m_irq()});
      if ($urandom_range(0, 2) == 0) rd_check($sformatf("rnd%0d_rd", n));
      st_check($sformatf("rnd%0d_st", n));
      if (n % 6 == 5) clr_flags(32'h1C);
    end
    while (q.size() != 0) rd_check("drain");
    rd_check("drain_empty");
    st_check("final_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
